arm_fetch: RTL
==============

ARM_FETCH -- requirements
Module: arm_fetch

Interface
REQ-001 Parameter FETCH_DEPTH, default 4, prefetch FIFO entries; power of two, 2..16.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch byte address; bits [1:0] SHALL be zero.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  instruction memory read request.
REQ-006 imem_addr  out  30  word address of request (byte address [31:2]).
REQ-007 imem_ack  in  1  request accepted; imem_rdata valid this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 inst_valid  out  1  FIFO head holds a valid instruction for the core.
REQ-010 inst  out  32  instruction at FIFO head.
REQ-011 inst_pc  out  32  byte address of inst, {word_addr, 2'b00}.
REQ-012 inst_ready  in  1  core consumes head this cycle.
REQ-013 redirect  in  1  branch/PC-write redirect from core.
REQ-014 redirect_pc  in  32  new fetch byte address; bits [1:0] ignored.
REQ-015 halt  in  1  stop issuing new fetches.
REQ-016 halted  out  1  no request outstanding and halt asserted.

Function
REQ-017 States: IDLE, REQ, DISCARD, HALT; one request outstanding at most.
REQ-018 Fetch pointer fpc[29:0] SHALL increment by 1 on each accepted (non-discarded) ack, wrapping 30'h3FFF_FFFF -> 0.
REQ-019 IDLE -> REQ when FIFO count < FETCH_DEPTH and halt=0; a request SHALL never be issued unless a free entry is guaranteed for its data.
REQ-020 In REQ, imem_req=1 and imem_addr SHALL remain stable until imem_ack; on ack, {fpc, imem_rdata} pushed, then REQ again if room and halt=0, else IDLE/HALT.
REQ-021 inst_valid = FIFO non-empty; pop when inst_valid & inst_ready; simultaneous push and pop leaves count unchanged.
REQ-022 inst_ready with inst_valid=0 SHALL have no effect.
REQ-023 redirect has highest priority: FIFO flushed (inst_valid=0 next cycle), fpc <= redirect_pc[31:2]; same-cycle pop and push ignored.
REQ-024 redirect with request outstanding and no ack that cycle -> DISCARD: imem_req and old imem_addr held until ack, data dropped, then REQ at new fpc.
REQ-025 redirect coinciding with imem_ack: data dropped, next cycle REQ at new fpc.
REQ-026 Latency: redirect at cycle N, nothing outstanding -> imem_req with new address at N+1; zero-wait ack at N+1 -> inst_valid at N+2.
REQ-027 Sustained throughput with zero-wait memory and inst_ready=1: one instruction per cycle after the initial 2-cycle latency.
REQ-028 halt=1: no new request; outstanding request completes and is pushed; then HALT with halted=1; FIFO continues to drain.
REQ-029 halt deasserted in HALT -> IDLE next cycle; redirect in HALT updates fpc and flushes, remains HALT.

Reset
REQ-030 During rst: imem_req=0, inst_valid=0, halted=0, FIFO empty, state IDLE, fpc=RESET_VECTOR[31:2]; imem_addr, inst, inst_pc SHALL read 0.
REQ-031 rst mid-request abandons it; imem_req=0 the cycle after rst sampled; ack during rst ignored.
REQ-032 First request SHALL issue the cycle after rst deasserts, at RESET_VECTOR.

Structure
REQ-033 FETCH_DEPTH default, RESET_VECTOR default, and state encodings SHALL live in the shared defines header alongside the CPSR bit definitions.
REQ-034 FIFO SHALL be a sub-module fetch_fifo (push, pop, flush, full, empty, count; 62-bit entries).
REQ-035 arm_fetch drives arm_core inst and accepts its inst_addr-derived redirect; no combinational path from inst_ready to imem_req.

Verification
REQ-036 Reset, zero-wait ack, inst_ready=1 -> inst_pc 0x0, 0x4, 0x8, 0xC on consecutive cycles from cycle 2.
REQ-037 inst_ready=0, FETCH_DEPTH=4 -> exactly 4 acks, imem_req=0 thereafter, inst_valid=1 holding pc 0x0.
REQ-038 Ack delayed 3 cycles, redirect to 0x100 in cycle 1 -> address 0x0 held until ack, data dropped, next imem_addr=0x40, first inst_pc=0x100.
REQ-039 Redirect to 0x200 same cycle as ack and pop -> dropped data, FIFO empty next cycle, next inst_pc=0x200.
REQ-040 halt=1 with request outstanding -> ack pushed, halted=1 next cycle, no further imem_req; FIFO drains; halt=0 resumes at next sequential address.
REQ-041 redirect_pc=0xFFFF_FFFC, zero-wait -> inst_pc 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// arm_fetch_pkg: shared core defines (CPSR bits, fetch unit defaults, fetch FSM states)
package arm_fetch_pkg;
    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;
    localparam int CPSR_I = 7;
    localparam int CPSR_F = 6;
    localparam int CPSR_T = 5;
    localparam int FETCH_DEPTH_DEF = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int FIFO_W = 62;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DISCARD, ST_HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue of {word_pc, instruction} entries
//   push/din   : write an entry (ignored when full)
//   pop/dout   : consume the head (ignored when empty); dout reads 0 when empty
//   flush      : drop all entries
//   full/empty/count : occupancy status
module fetch_fifo
    import arm_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEF,
    parameter int W = FIFO_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = empty ? '0 : mem[rd];
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            wr <= do_push ? wr + 1'b1 : wr;
            rd <= do_pop ? rd + 1'b1 : rd;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/arm_fetch.sv
// arm_fetch: instruction prefetch unit feeding arm_core from a single-outstanding imem port
//   imem_req/imem_addr/imem_ack/imem_rdata : word-addressed instruction memory port
//   inst_valid/inst/inst_pc/inst_ready     : FIFO head handed to the core
//   redirect/redirect_pc                   : branch or PC write, flushes and refetches
//   halt/halted                            : stop fetching; halted once nothing is outstanding
module arm_fetch
    import arm_fetch_pkg::*;
#(
    parameter int FETCH_DEPTH = FETCH_DEPTH_DEF,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);
    localparam int CW = $clog2(FETCH_DEPTH + 1);
    fetch_state_t state, state_nxt;
    logic [29:0] fpc, hold_addr;
    logic push, pop, full, empty, room;
    logic [CW-1:0] count;
    logic [CW:0] cnt_nxt;
    logic [61:0] head;
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];
    assign push = state == ST_REQ && imem_ack && !redirect && !full;
    assign pop = inst_valid && inst_ready && !redirect;
    // A new request is only launched if its data is guaranteed a slot after this cycle's push/pop.
    assign cnt_nxt = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign room = cnt_nxt < (CW+1)'(FETCH_DEPTH);
    fetch_fifo #(.DEPTH(FETCH_DEPTH), .W(FIFO_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({fpc, imem_rdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    state_nxt = halt ? ST_HALT : (room || redirect) ? ST_REQ : ST_IDLE;
            ST_REQ:     state_nxt = imem_ack ? (halt ? ST_HALT : (room || redirect) ? ST_REQ : ST_IDLE)
                                             : (redirect ? ST_DISCARD : ST_REQ);
            ST_DISCARD: state_nxt = imem_ack ? (halt ? ST_HALT : ST_REQ) : ST_DISCARD;
            ST_HALT:    state_nxt = halt ? ST_HALT : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end
    // hold_addr freezes the address of a request abandoned by redirect until memory acks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            fpc <= RESET_VECTOR[31:2];
            hold_addr <= '0;
        end else begin
            state <= state_nxt;
            fpc <= redirect ? redirect_pc[31:2] : push ? fpc + 30'd1 : fpc;
            if (state != ST_DISCARD) hold_addr <= fpc;
        end
    end
    assign imem_req = state == ST_REQ || state == ST_DISCARD;
    assign imem_addr = state == ST_REQ ? fpc : state == ST_DISCARD ? hold_addr : '0;
    assign inst_valid = !empty;
    assign inst = head[31:0];
    assign inst_pc = {head[61:32], 2'b00};
    assign halted = state == ST_HALT;
endmodule
